_load_store_unit: RTL and testbench

- Sits directly upstream of the data memory: accepts CPU load/store requests and drives the memory's MemRead, MemWrite, address and write_data, and consumes its read_data.
- Adds byte and halfword accesses (lb/lbu/lh/lhu/sb/sh) on top of the word-only data memory. Sub-word stores use read-modify-write.
- Raises a misalign/range error instead of touching memory.
- Multi-cycle and FSM-based; the core stalls on cpu_busy.

---
 rtl/_load_store_unit.sv | 168 ++++++++++++++++
 tb/tb__load_store_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/_load_store_unit.sv
// Load/store unit in front of a word-only data memory: adds byte/halfword
// accesses (sub-word stores by read-modify-write) and flags bad requests.
module _load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_ERR} state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS) * 32'd4;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        req_bad;
  logic [31:0] load_ext;
  logic [31:0] merge_val;

  assign req_bad = (cpu_size == 2'b11)
                 | ((cpu_size == 2'b01) & cpu_addr[0])
                 | ((cpu_size == 2'b10) & (|cpu_addr[1:0]))
                 | (cpu_addr >= ADDR_LIMIT);

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    h = 16'h0000;
    case (addr_q[1:0])
      2'd0:    b = mem_rdata[7:0];
      2'd1:    b = mem_rdata[15:8];
      2'd2:    b = mem_rdata[23:16];
      default: b = mem_rdata[31:24];
    endcase
    h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns_q ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    merge_val = mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merge_val[7:0]   = wdata_q[7:0];
        2'd1:    merge_val[15:8]  = wdata_q[7:0];
        2'd2:    merge_val[23:16] = wdata_q[7:0];
        default: merge_val[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          uns_d   = cpu_unsigned;
          size_d  = cpu_size;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          if (req_bad)                state_d = S_ERR;
          else if (!cpu_we)           state_d = S_LOAD;
          else if (cpu_size == 2'b10) state_d = S_WRITE;
          else                        state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_RMW_RD: begin
        merge_d = merge_val;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode straight from state so reset drops them immediately.
  assign MemRead   = (state_q == S_LOAD) || (state_q == S_RMW_RD);
  assign MemWrite  = (state_q == S_WRITE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = (size_q == 2'b10) ? wdata_q : merge_q;
  assign cpu_busy  = (state_q != S_IDLE);
  assign cpu_done  = done_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb__load_store_unit.sv
// Scoreboard bench for _load_store_unit with a behavioural word memory.
module tb__load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_unsigned = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_busy, cpu_done, cpu_err;
  logic        MemRead, MemWrite;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    int          due;
    bit          err;
    logic [31:0] rd;
    int          nrd;
    int          nwr;
  } exp_t;
  exp_t sb_q[$];

  _load_store_unit #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .cpu_err(cpu_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[6:2]];
  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr[6:2]] <= mem_wdata;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: tally strobes per operation and compare each done against the queue head.
  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (MemRead && MemWrite) chk("strobe_overlap", 32'd1, 32'd0);
      if (cpu_err && !cpu_done) chk("err_without_done", 32'd1, 32'd0);
      rd_cnt += int'(MemRead);
      wr_cnt += int'(MemWrite);
      if (cpu_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          x = sb_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(x.due));
          chk("cpu_err", {31'h0, cpu_err}, {31'h0, x.err});
          chk("cpu_rdata", cpu_rdata, x.rd);
          chk("memread_cycles", 32'(rd_cnt), 32'(x.nrd));
          chk("memwrite_cycles", 32'(wr_cnt), 32'(x.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic do_op(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit e, input logic [31:0] rv);
    exp_t x;
    int n;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_size = sz;
    cpu_unsigned = uns;
    cpu_addr = a;
    cpu_wdata = wd;
    @(posedge clk);
    n = cyc;
    x.due = n + ((!e && we && sz != 2'b10) ? 3 : 2);
    x.nrd = (!e && (!we || sz != 2'b10)) ? 1 : 0;
    x.nwr = (!e && we) ? 1 : 0;
    if (!e && !we) last_rd = rv;
    x.rd = last_rd;
    x.err = e;
    sb_q.push_back(x);
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (!cpu_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_busy"}, {31'h0, cpu_busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, cpu_done}, 32'h0);
    chk({tag, "_err"}, {31'h0, cpu_err}, 32'h0);
    chk({tag, "_memread"}, {31'h0, MemRead}, 32'h0);
    chk({tag, "_memwrite"}, {31'h0, MemWrite}, 32'h0);
  endtask

  logic [31:0] b2b_vals [3] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};

  initial begin
    exp_t x;
    int n;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Word path
    do_op(1, 2'b10, 0, 32'h4, 32'h12345678, 0, 32'h0);
    do_op(0, 2'b10, 0, 32'h4, 32'h0, 0, 32'h12345678);
    chk("mem_word1", mem[1], 32'h12345678);

    // Sub-word stores
    do_op(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'h0);
    do_op(1, 2'b00, 0, 32'h12, 32'hFFFFFFA5, 0, 32'h0);
    chk("mem_after_sb", mem[4], 32'h11A53344);
    do_op(1, 2'b01, 0, 32'h10, 32'h1234BEEF, 0, 32'h0);
    chk("mem_after_sh", mem[4], 32'h11A5BEEF);

    // Extension
    do_op(1, 2'b10, 0, 32'h0, 32'h80FF7F01, 0, 32'h0);
    do_op(0, 2'b00, 0, 32'h2, 32'h0, 0, 32'hFFFFFFFF);
    do_op(0, 2'b00, 1, 32'h2, 32'h0, 0, 32'h000000FF);
    do_op(0, 2'b01, 0, 32'h2, 32'h0, 0, 32'hFFFF80FF);
    do_op(0, 2'b01, 1, 32'h2, 32'h0, 0, 32'h000080FF);
    do_op(0, 2'b00, 0, 32'h0, 32'h0, 0, 32'h00000001);
    do_op(0, 2'b00, 0, 32'h1, 32'h0, 0, 32'h0000007F);
    do_op(0, 2'b01, 0, 32'h0, 32'h0, 0, 32'h00007F01);
    do_op(0, 2'b00, 0, 32'h3, 32'h0, 0, 32'hFFFFFF80);

    // Errors leave rdata and memory alone; last in-range word is legal
    do_op(0, 2'b10, 0, 32'h6, 32'h0, 1, 32'h0);
    do_op(0, 2'b01, 0, 32'h3, 32'h0, 1, 32'h0);
    do_op(0, 2'b11, 0, 32'h0, 32'h0, 1, 32'h0);
    do_op(1, 2'b10, 0, 32'h80, 32'hDEADBEEF, 1, 32'h0);
    do_op(1, 2'b00, 0, 32'hFFFFFFFC, 32'h55, 1, 32'h0);
    chk("mem0_after_err", mem[0], 32'h80FF7F01);
    do_op(0, 2'b10, 0, 32'h7C, 32'h0, 0, 32'h0);

    // Back-to-back with cpu_req held; data changed while busy must be ignored
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_size = 2'b10;
    cpu_addr = 32'h14;
    for (int k = 0; k < 3; k++) begin
      cpu_wdata = b2b_vals[k];
      @(posedge clk);
      x.due = cyc + 2;
      x.err = 1'b0;
      x.rd = last_rd;
      x.nrd = 0;
      x.nwr = 1;
      sb_q.push_back(x);
      @(negedge clk);
      cpu_wdata = 32'hDEAD0000 | 32'(k);
      @(negedge clk);
      chk("b2b_mem", mem[5], b2b_vals[k]);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_no_extra", mem[5], 32'hCAFE0003);

    // Reset in the middle of a read-modify-write
    do_op(1, 2'b10, 0, 32'h8, 32'hAABBCCDD, 0, 32'h0);
    do_op(0, 2'b10, 0, 32'h4, 32'h0, 0, 32'h12345678);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_size = 2'b00;
    cpu_addr = 32'h8;
    cpu_wdata = 32'h00000099;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    chk("rmw_memread", {31'h0, MemRead}, 32'h1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk);
    #1 rst = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    chk("mem_after_rst", mem[2], 32'hAABBCCDD);
    do_op(0, 2'b10, 0, 32'h8, 32'h0, 0, 32'hAABBCCDD);

    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
